// File: rtl/dpram_pkg.sv
// Shared constants and helper functions for the byte-enable dual-port RAM.
// Provides read-mode encodings, byte count, byte merge and per-byte parity.
package dpram_pkg;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

    // Helpers work on a wide container; callers extend and truncate.
    localparam int MAX_DW = 512;
    localparam int MAX_NB = MAX_DW / 8;

    function automatic int nbytes(input int dw);
        return dw / 8;
    endfunction

    function automatic logic [MAX_DW-1:0] byte_merge(
        input logic [MAX_DW-1:0] old_w,
        input logic [MAX_DW-1:0] new_w,
        input logic [MAX_NB-1:0] mask
    );
        logic [MAX_DW-1:0] r;
        r = old_w;
        for (int b = 0; b < MAX_NB; b++) begin
            if (mask[b]) begin
                r[b*8 +: 8] = new_w[b*8 +: 8];
            end
        end
        return r;
    endfunction

    // Even parity: the bit that makes the byte plus parity have even weight.
    function automatic logic [MAX_NB-1:0] parity_gen(
        input logic [MAX_DW-1:0] w
    );
        logic [MAX_NB-1:0] p;
        for (int b = 0; b < MAX_NB; b++) begin
            p[b] = ^w[b*8 +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/dpram_rd_port.sv
// Registered read path of one RAM port: read-mode mux, out-of-range zeroing,
// output/valid register and (with DPRAM_PARITY_EN) per-byte parity check.
// Ports: clk, rst, acc_i (access this cycle), wr_i (write this cycle),
//   in_range_i, byte_en_i, old_i (pre-write word), new_i (write data),
//   data_o, valid_o; parity build adds old_par_i, err_inj_i, par_err_o.
module dpram_rd_port
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int READ_MODE  = 0,
    localparam int NBYTES    = nbytes(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  acc_i,
    input  logic                  wr_i,
    input  logic                  in_range_i,
    input  logic [NBYTES-1:0]     byte_en_i,
    input  logic [DATA_WIDTH-1:0] old_i,
    input  logic [DATA_WIDTH-1:0] new_i,
`ifdef DPRAM_PARITY_EN
    input  logic [NBYTES-1:0]     old_par_i,
    input  logic                  err_inj_i,
    output logic [NBYTES-1:0]     par_err_o,
`endif
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] merged;
    logic                  wr_first;

    assign merged = DATA_WIDTH'(byte_merge(MAX_DW'(old_i), MAX_DW'(new_i),
                                           MAX_NB'(byte_en_i)));
    assign wr_first = (READ_MODE == WRITE_FIRST) && wr_i;

    always_comb begin
        data_d = '0;
        if (in_range_i) begin
            data_d = wr_first ? merged : old_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= acc_i;
            if (acc_i) begin
                data_q <= data_d;
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

`ifdef DPRAM_PARITY_EN
    logic [NBYTES-1:0] new_par, mrg_par, chk_par, perr_d, perr_q;

    // Parity that a written byte will carry once stored (inverted on inject).
    assign new_par = NBYTES'(parity_gen(MAX_DW'(new_i)))
                   ^ {NBYTES{err_inj_i}};
    assign mrg_par = (old_par_i & ~byte_en_i) | (new_par & byte_en_i);
    assign chk_par = wr_first ? mrg_par : old_par_i;

    always_comb begin
        perr_d = '0;
        if (in_range_i) begin
            perr_d = NBYTES'(parity_gen(MAX_DW'(data_d))) ^ chk_par;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= '0;
        end else if (acc_i) begin
            perr_q <= perr_d;
        end
    end

    assign par_err_o = perr_q & {NBYTES{valid_q}};
`endif

endmodule

// File: rtl/dual_port_ram_be.sv
// True dual-port RAM with per-byte write enables, registered reads with
// valid strobes, selectable same-port read-during-write and collision flag.
// Ports: clk, rst, per port x: port_en_x, wr_en_x, byte_en_x, addr_in_x,
//   data_in_x, data_out_x, rd_valid_x; shared wr_collision.
// Optional DPRAM_PARITY_EN adds err_inj_x inputs and par_err_x outputs.
module dual_port_ram_be
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64,
    parameter int READ_MODE  = READ_FIRST,
    localparam int NBYTES    = nbytes(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  port_en_0,
    input  logic                  wr_en_0,
    input  logic [NBYTES-1:0]     byte_en_0,
    input  logic [ADDR_WIDTH-1:0] addr_in_0,
    input  logic [DATA_WIDTH-1:0] data_in_0,
    output logic [DATA_WIDTH-1:0] data_out_0,
    output logic                  rd_valid_0,
    input  logic                  port_en_1,
    input  logic                  wr_en_1,
    input  logic [NBYTES-1:0]     byte_en_1,
    input  logic [ADDR_WIDTH-1:0] addr_in_1,
    input  logic [DATA_WIDTH-1:0] data_in_1,
    output logic [DATA_WIDTH-1:0] data_out_1,
    output logic                  rd_valid_1,
`ifdef DPRAM_PARITY_EN
    input  logic                  err_inj_0,
    input  logic                  err_inj_1,
    output logic [NBYTES-1:0]     par_err_0,
    output logic [NBYTES-1:0]     par_err_1,
`endif
    output logic                  wr_collision
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  pen   [2];
    logic                  pwe   [2];
    logic [NBYTES-1:0]     pbe   [2];
    logic [ADDR_WIDTH-1:0] paddr [2];
    logic [DATA_WIDTH-1:0] pdin  [2];

    logic                  acc   [2];
    logic                  wr    [2];
    logic                  inr   [2];
    logic                  wrm   [2];
    logic [DATA_WIDTH-1:0] old_w [2];

    logic col_d, col_q;

    assign pen[0]   = port_en_0;
    assign pen[1]   = port_en_1;
    assign pwe[0]   = wr_en_0;
    assign pwe[1]   = wr_en_1;
    assign pbe[0]   = byte_en_0;
    assign pbe[1]   = byte_en_1;
    assign paddr[0] = addr_in_0;
    assign paddr[1] = addr_in_1;
    assign pdin[0]  = data_in_0;
    assign pdin[1]  = data_in_1;

    // Accesses during reset are discarded entirely.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            acc[p]   = pen[p] & ~rst;
            wr[p]    = acc[p] & pwe[p];
            inr[p]   = {1'b0, paddr[p]} < (ADDR_WIDTH+1)'(DEPTH);
            wrm[p]   = wr[p] & inr[p];
            old_w[p] = inr[p] ? mem_q[paddr[p]] : '0;
        end
    end

    // Port 1 is applied first so port 0 wins any byte both ports enable.
    always_ff @(posedge clk) begin
        for (int p = 1; p >= 0; p--) begin
            if (wrm[p]) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (pbe[p][b]) begin
                        mem_q[paddr[p]][b*8 +: 8] <= pdin[p][b*8 +: 8];
                    end
                end
            end
        end
    end

    // Collision flags the address match even when the masks do not overlap.
    assign col_d = wrm[0] & wrm[1] & (paddr[0] == paddr[1])
                 & (|pbe[0]) & (|pbe[1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= 1'b0;
        end else begin
            col_q <= col_d;
        end
    end

    assign wr_collision = col_q;

`ifdef DPRAM_PARITY_EN
    logic [NBYTES-1:0] par_q   [DEPTH];
    logic [NBYTES-1:0] old_par [2];
    logic              pei     [2];

    assign pei[0] = err_inj_0;
    assign pei[1] = err_inj_1;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            old_par[p] = inr[p] ? par_q[paddr[p]] : '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 1; p >= 0; p--) begin
            if (wrm[p]) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (pbe[p][b]) begin
                        par_q[paddr[p]][b] <= (^pdin[p][b*8 +: 8]) ^ pei[p];
                    end
                end
            end
        end
    end
`endif

    dpram_rd_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .READ_MODE  (READ_MODE)
    ) u_rd0 (
        .clk        (clk),
        .rst        (rst),
        .acc_i      (acc[0]),
        .wr_i       (wr[0]),
        .in_range_i (inr[0]),
        .byte_en_i  (pbe[0]),
        .old_i      (old_w[0]),
        .new_i      (pdin[0]),
`ifdef DPRAM_PARITY_EN
        .old_par_i  (old_par[0]),
        .err_inj_i  (pei[0]),
        .par_err_o  (par_err_0),
`endif
        .data_o     (data_out_0),
        .valid_o    (rd_valid_0)
    );

    dpram_rd_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .READ_MODE  (READ_MODE)
    ) u_rd1 (
        .clk        (clk),
        .rst        (rst),
        .acc_i      (acc[1]),
        .wr_i       (wr[1]),
        .in_range_i (inr[1]),
        .byte_en_i  (pbe[1]),
        .old_i      (old_w[1]),
        .new_i      (pdin[1]),
`ifdef DPRAM_PARITY_EN
        .old_par_i  (old_par[1]),
        .err_inj_i  (pei[1]),
        .par_err_o  (par_err_1),
`endif
        .data_o     (data_out_1),
        .valid_o    (rd_valid_1)
    );

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be: a read-first and a write-first instance share
// stimulus and are compared every cycle against an array-based model.
module tb_dual_port_ram_be;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int DP = 48;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          pen [2];
    logic          pwe [2];
    logic [3:0]    pbe [2];
    logic [AW-1:0] pa  [2];
    logic [DW-1:0] pd  [2];
    logic          pei [2];

    logic [DW-1:0] o_do  [2][2];
    logic          o_v   [2][2];
    logic          o_col [2];
    logic [3:0]    o_pe  [2][2];

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] m_mem [DP];
    logic [3:0]    m_cor [DP];
    logic [DW-1:0] e_do  [2][2];
    logic [3:0]    e_pe  [2][2];
    logic          e_v   [2];
    logic          e_col;

    for (genvar m = 0; m < 2; m++) begin : g_dut
        dual_port_ram_be #(
            .DATA_WIDTH (DW),
            .ADDR_WIDTH (AW),
            .DEPTH      (DP),
            .READ_MODE  (m)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .port_en_0    (pen[0]),
            .wr_en_0      (pwe[0]),
            .byte_en_0    (pbe[0]),
            .addr_in_0    (pa[0]),
            .data_in_0    (pd[0]),
            .data_out_0   (o_do[m][0]),
            .rd_valid_0   (o_v[m][0]),
            .port_en_1    (pen[1]),
            .wr_en_1      (pwe[1]),
            .byte_en_1    (pbe[1]),
            .addr_in_1    (pa[1]),
            .data_in_1    (pd[1]),
            .data_out_1   (o_do[m][1]),
            .rd_valid_1   (o_v[m][1]),
`ifdef DPRAM_PARITY_EN
            .err_inj_0    (pei[0]),
            .err_inj_1    (pei[1]),
            .par_err_0    (o_pe[m][0]),
            .par_err_1    (o_pe[m][1]),
`endif
            .wr_collision (o_col[m])
        );
`ifndef DPRAM_PARITY_EN
        assign o_pe[m][0] = 4'h0;
        assign o_pe[m][1] = 4'h0;
`endif
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mrg(input logic [DW-1:0] o,
                                          input logic [DW-1:0] n,
                                          input logic [3:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    task automatic cyc();
        logic [DW-1:0] old;
        logic [3:0]    oc;
        logic          ir [2];
        for (int p = 0; p < 2; p++) ir[p] = (pa[p] < DP);
        if (rst) begin
            for (int m = 0; m < 2; m++)
                for (int p = 0; p < 2; p++) begin
                    e_do[m][p] = '0;
                    e_pe[m][p] = '0;
                end
            e_v[0] = 1'b0;
            e_v[1] = 1'b0;
            e_col = 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                e_v[p] = pen[p];
                if (pen[p]) begin
                    old = ir[p] ? m_mem[pa[p]] : '0;
                    oc  = ir[p] ? m_cor[pa[p]] : '0;
                    e_do[0][p] = old;
                    e_pe[0][p] = oc;
                    e_do[1][p] = old;
                    e_pe[1][p] = oc;
                    if (pwe[p] && ir[p]) begin
                        e_do[1][p] = mrg(old, pd[p], pbe[p]);
                        e_pe[1][p] = (oc & ~pbe[p]) | ({4{pei[p]}} & pbe[p]);
                    end
                end
            end
            e_col = pen[0] && pwe[0] && pen[1] && pwe[1] && ir[0] && ir[1]
                 && pa[0] == pa[1] && pbe[0] != 0 && pbe[1] != 0;
            for (int p = 1; p >= 0; p--) begin
                if (pen[p] && pwe[p] && ir[p]) begin
                    m_mem[pa[p]] = mrg(m_mem[pa[p]], pd[p], pbe[p]);
                    m_cor[pa[p]] = (m_cor[pa[p]] & ~pbe[p])
                                 | ({4{pei[p]}} & pbe[p]);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("m%0d_data_out_%0d", m, p), 64'(o_do[m][p]),
                    64'(e_do[m][p]));
                chk($sformatf("m%0d_rd_valid_%0d", m, p), 64'(o_v[m][p]),
                    64'(e_v[p]));
`ifdef DPRAM_PARITY_EN
                chk($sformatf("m%0d_par_err_%0d", m, p), 64'(o_pe[m][p]),
                    64'(e_pe[m][p] & {4{e_v[p]}}));
`endif
            end
            chk($sformatf("m%0d_wr_collision", m), 64'(o_col[m]), 64'(e_col));
        end
    endtask

    task automatic drv(input int p, input logic en, input logic we,
                       input logic [3:0] be, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic ei);
        pen[p] = en;
        pwe[p] = we;
        pbe[p] = be;
        pa[p]  = a;
        pd[p]  = d;
        pei[p] = ei;
    endtask

    task automatic idle();
        drv(0, 0, 0, 4'h0, '0, '0, 0);
        drv(1, 0, 0, 4'h0, '0, '0, 0);
    endtask

    initial begin
        for (int i = 0; i < DP; i++) begin
            m_mem[i] = '0;
            m_cor[i] = '0;
        end
        for (int m = 0; m < 2; m++)
            for (int p = 0; p < 2; p++) begin
                e_do[m][p] = '0;
                e_pe[m][p] = '0;
            end
        e_v[0] = 0;
        e_v[1] = 0;
        e_col = 0;
        idle();

        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;

        // Give every word a known value so the model tracks the array.
        for (int i = 0; i < DP / 2; i++) begin
            drv(0, 1, 1, 4'hF, AW'(i), '0, 0);
            drv(1, 1, 1, 4'hF, AW'(i + DP / 2), '0, 0);
            cyc();
        end
        idle();

        // Fill via port 0, read back via port 1.
        for (int i = 0; i < 16; i++) begin
            drv(0, 1, 1, 4'hF, AW'(i), 32'h100 + i, 0);
            cyc();
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            drv(1, 1, 0, 4'h0, AW'(i), '0, 0);
            cyc();
            chk("fill_rd", 64'(o_do[0][1]), 64'(32'h100 + i));
            chk("fill_vld", 64'(o_v[0][1]), 64'd1);
        end
        idle();
        cyc();
        chk("fill_vld_drop", 64'(o_v[0][1]), 64'd0);

        // Byte mask merge.
        drv(0, 1, 1, 4'hF, 6'd5, 32'hAABBCCDD, 0);
        cyc();
        drv(0, 1, 1, 4'b0101, 6'd5, 32'h11223344, 0);
        cyc();
        idle();
        drv(1, 1, 0, 4'h0, 6'd5, '0, 0);
        cyc();
        chk("byte_mask", 64'(o_do[0][1]), 64'h00000000AA22CC44);

        // Read-during-write on address 3.
        idle();
        drv(0, 1, 1, 4'hF, 6'd3, '0, 0);
        cyc();
        drv(0, 1, 1, 4'hF, 6'd3, 32'hDEADBEEF, 0);
        drv(1, 1, 0, 4'h0, 6'd3, '0, 0);
        cyc();
        chk("rdw_rf_same", 64'(o_do[0][0]), 64'h0);
        chk("rdw_wf_same", 64'(o_do[1][0]), 64'h00000000DEADBEEF);
        chk("rdw_rf_cross", 64'(o_do[0][1]), 64'h0);
        chk("rdw_wf_cross", 64'(o_do[1][1]), 64'h0);

        // Write collision on address 7.
        drv(0, 1, 1, 4'b0011, 6'd7, 32'h11111111, 0);
        drv(1, 1, 1, 4'b1111, 6'd7, 32'h22222222, 0);
        cyc();
        chk("col_pulse", 64'(o_col[0]), 64'd1);
        idle();
        drv(0, 1, 0, 4'h0, 6'd7, '0, 0);
        cyc();
        chk("col_clear", 64'(o_col[0]), 64'd0);
        chk("col_data", 64'(o_do[0][0]), 64'h0000000022221111);

        // Out-of-range write then read.
        idle();
        drv(0, 1, 1, 4'hF, 6'd50, 32'hFFFFFFFF, 0);
        cyc();
        drv(0, 1, 0, 4'h0, 6'd50, '0, 0);
        cyc();
        chk("oor_data", 64'(o_do[0][0]), 64'h0);
        chk("oor_vld", 64'(o_v[0][0]), 64'd1);
        idle();
        for (int i = 0; i < DP; i++) begin
            drv(1, 1, 0, 4'h0, AW'(i), '0, 0);
            cyc();
        end

        // Reset during a read, with a write presented under reset.
        idle();
        drv(0, 1, 0, 4'h0, 6'd5, '0, 0);
        drv(1, 1, 1, 4'hF, 6'd5, 32'h0, 0);
        rst = 1'b1;
        cyc();
        chk("rst_vld", 64'(o_v[0][0]), 64'd0);
        chk("rst_data", 64'(o_do[0][0]), 64'h0);
        rst = 1'b0;
        idle();
        drv(0, 1, 0, 4'h0, 6'd5, '0, 0);
        cyc();
        chk("rst_nowrite", 64'(o_do[0][0]), 64'h00000000AA22CC44);

`ifdef DPRAM_PARITY_EN
        idle();
        drv(0, 1, 1, 4'b0100, 6'd9, 32'h00C30000, 1);
        cyc();
        drv(0, 1, 0, 4'h0, 6'd9, '0, 0);
        cyc();
        chk("par_inj", 64'(o_pe[0][0]), 64'h4);
        drv(0, 1, 1, 4'b0100, 6'd9, 32'h00C30000, 0);
        cyc();
        drv(0, 1, 0, 4'h0, 6'd9, '0, 0);
        cyc();
        chk("par_clr", 64'(o_pe[0][0]), 64'h0);
`endif

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            for (int p = 0; p < 2; p++) begin
                drv(p, ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                    4'($urandom), AW'($urandom_range(0, DP + 7)), $urandom,
                    ($urandom_range(0, 5) == 0));
            end
            if ($urandom_range(0, 3) == 0) pa[1] = pa[0];
            rst = ($urandom_range(0, 39) == 0);
            cyc();
        end
        rst = 1'b0;
        idle();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_be.md
Name: dual_port_ram_be

Overview:
- Parametrised true dual-port RAM; successor to the single-write-port dual_port_ram.
- Two fully independent read/write ports share one clock and one storage array.
- Adds per-byte write enables, a registered read with valid strobe, a selectable same-port read-during-write mode, and defined write-collision arbitration with a collision flag.
- Used as scratch/buffer memory between two datapath agents.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 6, address width.
- DEPTH, 64, number of words; must be <= 2**ADDR_WIDTH.
- READ_MODE, 0, same-port read-during-write result: 0 = read-first (old data), 1 = write-first (new data).
- Derived, not overridable: NBYTES = DATA_WIDTH/8.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- port_en_0  input  1  port 0 access enable
- wr_en_0  input  1  port 0 write (1) / read (0); ignored when port_en_0=0
- byte_en_0  input  NBYTES  port 0 byte write mask
- addr_in_0  input  ADDR_WIDTH  port 0 address
- data_in_0  input  DATA_WIDTH  port 0 write data
- data_out_0  output  DATA_WIDTH  port 0 registered read data
- rd_valid_0  output  1  port 0 read data valid
- port_en_1, wr_en_1, byte_en_1, addr_in_1, data_in_1, data_out_1, rd_valid_1: same as port 0, for port 1
- wr_collision  output  1  one-cycle pulse: both ports wrote the same address

Behaviour:
- Reset: data_out_0/1 = 0, rd_valid_0/1 = 0, wr_collision = 0.
  - Array contents are not cleared.
  - Any access presented while rst=1 is ignored; no write occurs.
- Write: at the edge where port_en_x=1 and wr_en_x=1, each byte b with byte_en_x[b]=1 is updated. Other bytes are unchanged.
- Read: every access with port_en_x=1 (read or write) updates data_out_x at that edge and sets rd_valid_x=1 for the following cycle. Latency is 1.
  - port_en_x=0: rd_valid_x=0 next cycle; data_out_x holds its last value.
- Same-port read-during-write:
  - READ_MODE=0: data_out_x = pre-write word.
  - READ_MODE=1: data_out_x = merged word (new bytes where byte_en_x set, old bytes elsewhere).
- Cross-port read of an address the other port writes in the same cycle: always returns the pre-write word.
- Both ports write the same address in the same cycle:
  - Bytes enabled on port 0 take port 0 data.
  - Bytes enabled only on port 1 take port 1 data.
  - wr_collision=1 in the next cycle, even when the byte masks do not overlap.
- Address >= DEPTH:
  - Write is dropped.
  - Read returns 0 with rd_valid=1.
  - No wrap-around.
- byte_en_x = 0 with wr_en_x=1: no storage change; still counts as an access (read and rd_valid behaviour as above). Not a collision.
- Reset asserted mid-stream: the outputs defined under Reset clear at the reset edge, and the in-flight read result is discarded.

Optional Feature:
- Macro: DPRAM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte.
  - Adds ports par_err_0 and par_err_1 (output, NBYTES): registered with data_out_x, qualified by rd_valid_x, one bit per byte.
  - Adds ports err_inj_0 and err_inj_1 (input, 1): when high on a write, the stored parity of every written byte is inverted.
  - Bytes not written keep their stored parity.
- Undefined: no parity storage and none of these four ports exist.

Decomposition:
- Package dpram_pkg:
  - READ_FIRST=0 and WRITE_FIRST=1 constants.
  - Function for NBYTES.
  - Byte-merge function (old word, new word, mask).
  - Parity-generate function.
- Sub-module dpram_rd_port:
  - Instantiated twice.
  - Owns the data_out/rd_valid register, out-of-range zeroing, the READ_MODE mux and the parity check.
- Array and collision arbitration stay in the top level.

Test Plan:
- Reset then fill: port 0 writes addr 0..15 with data 0x100+i and byte_en=4'hF; port 1 reads 0..15 → data_out_1 = 0x100+i one cycle after each address, rd_valid_1=1 throughout, 0 after port_en_1 drops.
- Byte mask: write 0xAABBCCDD to addr 5, then 0x11223344 with byte_en=4'b0101 → read returns 0xAA22CC44.
- Read-during-write on addr 3 (old 0x0, write 0xDEADBEEF):
  - READ_MODE=0 → data_out_0=0x0.
  - READ_MODE=1 → data_out_0=0xDEADBEEF.
  - Port 1 reading addr 3 in the same cycle → 0x0 in both modes.
- Collision at addr 7: port 0 writes 0x11111111 with byte_en=4'b0011; port 1 writes 0x22222222 with byte_en=4'b1111 → stored 0x22221111; wr_collision pulses exactly one cycle.
- Boundary and reset: DEPTH=48; write to addr 50 then read addr 50 → 0 with rd_valid=1, and addr 0..47 unchanged. Assert rst during a read → rd_valid=0 and data_out=0 next cycle; a write presented during rst leaves memory unchanged.
- DPRAM_PARITY_EN defined:
  - Write addr 9 with err_inj_0=1, byte_en=4'b0100 → read addr 9 gives par_err_0=4'b0100.
  - Rewrite addr 9 with err_inj_0=0 → par_err_0=0.
